// File: rtl/snoop_responder_if.sv
// ----------------------------------------------------------------------------
// snoop_responder_if
// Groups the coherence-bus snoop handshake and the dcache frame-array
// read/write port used by snoop_responder.
//
// Signals (direction as seen by the responder, modport slave):
//   ccwait        in   snoop request from the coherence controller
//   ccinv         in   snoop demands invalidation (BusRdX), valid with ccwait
//   ccsnoopaddr   in   snooped word address {tag[31:6], index[5:3], blk[2], byte[1:0]}
//   cctrans       out  snoop response / transfer active
//   ccwrite       out  block held Modified, data being supplied
//   snoop_dstore  out  data word driven onto the bus
//   dwait         in   bus has not yet accepted the current data word
//   cache_busy    in   dcache mid-transaction, new snoops deferred
//   snp_idx       out  frame index presented to the dcache arrays
//   snp_tag/valid/dirty/data0/data1  in  combinational array read at snp_idx
//   st_wen/st_valid/st_dirty         out frame state write at snp_idx
// modport master is the environment side (bus plus dcache arrays).
// ----------------------------------------------------------------------------
interface snoop_responder_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 26;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 32;

    logic              ccwait;
    logic              ccinv;
    logic [ADDR_W-1:0] ccsnoopaddr;
    logic              cctrans;
    logic              ccwrite;
    logic [DATA_W-1:0] snoop_dstore;
    logic              dwait;
    logic              cache_busy;
    logic [IDX_W-1:0]  snp_idx;
    logic [TAG_W-1:0]  snp_tag;
    logic              snp_valid;
    logic              snp_dirty;
    logic [DATA_W-1:0] snp_data0;
    logic [DATA_W-1:0] snp_data1;
    logic              st_wen;
    logic              st_valid;
    logic              st_dirty;

    modport slave (
        input  ccwait, ccinv, ccsnoopaddr, dwait, cache_busy,
        input  snp_tag, snp_valid, snp_dirty, snp_data0, snp_data1,
        output cctrans, ccwrite, snoop_dstore, snp_idx,
        output st_wen, st_valid, st_dirty
    );

    modport master (
        output ccwait, ccinv, ccsnoopaddr, dwait, cache_busy,
        output snp_tag, snp_valid, snp_dirty, snp_data0, snp_data1,
        input  cctrans, ccwrite, snoop_dstore, snp_idx,
        input  st_wen, st_valid, st_dirty
    );
endinterface

// File: rtl/snoop_responder.sv
// ----------------------------------------------------------------------------
// snoop_responder
// Answers coherence snoops on behalf of a direct-mapped, two-word-block data
// cache. A snoop is captured in IDLE, looked up against the frame arrays,
// answered with a one-cycle response (miss / Shared) or a two-word write-back
// (Modified), and finally the frame state is downgraded or invalidated.
//
// Ports:
//   CLK           in   clock, rising edge
//   RST           in   asynchronous active-high reset
//   bus           snoop_responder_if.slave (snoop handshake + frame arrays)
//   snoop_hits    out  16-bit saturating count of lookup hits   (SNOOP_STATS_EN)
//   snoop_wbs     out  16-bit saturating count of write-backs   (SNOOP_STATS_EN)
//
// Build option: define SNOOP_STATS_EN to add the snoop_hits / snoop_wbs
// statistics outputs. Without it those ports and counters do not exist and
// the responder behaves identically otherwise.
//
// All outputs are registered and reflect the current FSM state only.
// ----------------------------------------------------------------------------
module snoop_responder (
    input  logic             CLK,
    input  logic             RST,
    snoop_responder_if.slave bus
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]      snoop_hits,
    output logic [15:0]      snoop_wbs
`endif
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TAG_W   = 26;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_LSB = 6;
    localparam int unsigned IDX_LSB = 3;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_RESP   = 3'd2,
        S_WB0    = 3'd3,
        S_WB1    = 3'd4,
        S_UPDATE = 3'd5
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_tag;
    logic               r_inv;
    logic               r_hit;
    logic               r_dirty;
    logic [IDX_W-1:0]   r_snp_idx;
    logic               r_cctrans;
    logic               r_ccwrite;
    logic [DATA_W-1:0]  r_dstore;
    logic               r_st_wen;
    logic               r_st_valid;
    logic               r_st_dirty;

    logic               w_hit;
    logic               w_upd_wen;
    logic               w_upd_valid;
    logic               w_unused_offset;

    // Tag compare against the frame currently presented on snp_idx.
    assign w_hit = bus.snp_valid && (bus.snp_tag == r_tag);

    // Frame state update for the UPDATE cycle:
    //   invalidating snoop on a hit      -> I
    //   plain read of a Modified block   -> S (clean copy kept)
    //   Shared hit without invalidation  -> untouched
    assign w_upd_wen   = r_hit && (r_inv || r_dirty);
    assign w_upd_valid = w_upd_wen && !r_inv;

    // Block and byte offsets do not take part in a whole-block snoop.
    assign w_unused_offset = ^bus.ccsnoopaddr[IDX_LSB-1:0];

    // Snoop FSM with registered outputs; every output defaults to 0 and is
    // set only on the transition into the state that owns it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_tag      <= '0;
            r_inv      <= 1'b0;
            r_hit      <= 1'b0;
            r_dirty    <= 1'b0;
            r_snp_idx  <= '0;
            r_cctrans  <= 1'b0;
            r_ccwrite  <= 1'b0;
            r_dstore   <= '0;
            r_st_wen   <= 1'b0;
            r_st_valid <= 1'b0;
            r_st_dirty <= 1'b0;
        end else begin
            r_cctrans  <= 1'b0;
            r_ccwrite  <= 1'b0;
            r_dstore   <= '0;
            r_st_wen   <= 1'b0;
            r_st_valid <= 1'b0;
            r_st_dirty <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_snp_idx <= '0;
                    if (bus.ccwait && !bus.cache_busy) begin
                        r_tag     <= bus.ccsnoopaddr[ADDR_W-1:TAG_LSB];
                        r_snp_idx <= bus.ccsnoopaddr[TAG_LSB-1:IDX_LSB];
                        r_inv     <= bus.ccinv;
                        r_state   <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (!bus.ccwait) begin
                        // Requester withdrew before any response: drop it.
                        r_snp_idx <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_hit     <= w_hit;
                        r_dirty   <= w_hit && bus.snp_dirty;
                        r_cctrans <= 1'b1;
                        if (w_hit && bus.snp_dirty) begin
                            r_ccwrite <= 1'b1;
                            r_dstore  <= bus.snp_data0;
                            r_state   <= S_WB0;
                        end else begin
                            r_state   <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    if (!bus.ccwait) begin
                        r_snp_idx <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_st_wen   <= w_upd_wen;
                        r_st_valid <= w_upd_valid;
                        r_st_dirty <= 1'b0;
                        r_state    <= S_UPDATE;
                    end
                end

                // Write-back ignores ccwait: once data is on the bus the block
                // must be fully transferred and its state updated.
                S_WB0: begin
                    r_cctrans <= 1'b1;
                    r_ccwrite <= 1'b1;
                    if (bus.dwait) begin
                        r_dstore <= bus.snp_data0;
                    end else begin
                        r_dstore <= bus.snp_data1;
                        r_state  <= S_WB1;
                    end
                end

                S_WB1: begin
                    if (bus.dwait) begin
                        r_cctrans <= 1'b1;
                        r_ccwrite <= 1'b1;
                        r_dstore  <= bus.snp_data1;
                    end else begin
                        r_st_wen   <= w_upd_wen;
                        r_st_valid <= w_upd_valid;
                        r_st_dirty <= 1'b0;
                        r_state    <= S_UPDATE;
                    end
                end

                // Always returns through one IDLE cycle, so a ccwait held high
                // cannot chain straight into the next snoop.
                S_UPDATE: begin
                    r_snp_idx <= '0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_snp_idx <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cctrans      = r_cctrans;
    assign bus.ccwrite      = r_ccwrite;
    assign bus.snoop_dstore = r_dstore;
    assign bus.snp_idx      = r_snp_idx;
    assign bus.st_wen       = r_st_wen;
    assign bus.st_valid     = r_st_valid;
    assign bus.st_dirty     = r_st_dirty;

`ifdef SNOOP_STATS_EN
    logic [CNT_W-1:0] r_snoop_hits;
    logic [CNT_W-1:0] r_snoop_wbs;

    // Saturating event counters: lookup hits and completed write-backs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_snoop_hits <= '0;
            r_snoop_wbs  <= '0;
        end else begin
            if ((r_state == S_LOOKUP) && bus.ccwait && w_hit &&
                (r_snoop_hits != {CNT_W{1'b1}})) begin
                r_snoop_hits <= r_snoop_hits + CNT_W'(1);
            end
            if ((r_state == S_WB1) && !bus.dwait &&
                (r_snoop_wbs != {CNT_W{1'b1}})) begin
                r_snoop_wbs <= r_snoop_wbs + CNT_W'(1);
            end
        end
    end

    assign snoop_hits = r_snoop_hits;
    assign snoop_wbs  = r_snoop_wbs;
`endif

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL: RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL: ccwait  in  1  coherence controller snoop request.
REQ-004 SHALL: ccinv  in  1  snoop demands invalidation (BusRdX); valid with ccwait.
REQ-005 SHALL: ccsnoopaddr  in  32  snooped word address; tag [31:6], index [5:3], block offset [2], byte offset [1:0].
REQ-006 SHALL: cctrans  out  1  snoop response/transfer active.
REQ-007 SHALL: ccwrite  out  1  this cache holds block Modified and is supplying data.
REQ-008 SHALL: snoop_dstore  out  32  data word supplied on the bus.
REQ-009 SHALL: dwait  in  1  bus not yet accepting current snoop_dstore word.
REQ-010 SHALL: cache_busy  in  1  dcache mid-transaction; new snoops deferred.
REQ-011 SHALL: snp_idx  out  3  frame index presented to dcache arrays.
REQ-012 SHALL: snp_tag  in  26; snp_valid, snp_dirty  in  1; snp_data0, snp_data1  in  32 -- combinational array read at snp_idx.
REQ-013 SHALL: st_wen  out  1; st_valid, st_dirty  out  1 -- frame state write at snp_idx.

Function
REQ-014 SHALL: FSM states IDLE, LOOKUP, RESP, WB0, WB1, UPDATE.
REQ-015 SHALL: IDLE, ccwait=1 and cache_busy=0 -> capture ccsnoopaddr and ccinv into registers, go LOOKUP; cache_busy=1 holds IDLE.
REQ-016 SHALL: snp_idx driven from captured address bits [5:3] in all non-IDLE states; 0 in IDLE.
REQ-017 SHALL: LOOKUP: hit = snp_valid and snp_tag equal captured [31:6]; hit and snp_dirty -> WB0, else -> RESP; hit/dirty registered.
REQ-018 SHALL: RESP: cctrans=1, ccwrite=0 for exactly one cycle, then UPDATE.
REQ-019 SHALL: WB0: cctrans=1, ccwrite=1, snoop_dstore=snp_data0; stay while dwait=1; dwait=0 -> WB1.
REQ-020 SHALL: WB1: same with snp_data1; dwait=0 -> UPDATE.
REQ-021 SHALL: UPDATE: one cycle, then IDLE; miss -> st_wen=0; hit with captured ccinv=1 -> st_wen=1, st_valid=0, st_dirty=0; hit Modified without ccinv -> st_wen=1, st_valid=1, st_dirty=0 (M->S); hit Shared without ccinv -> st_wen=0.
REQ-022 SHALL: ccwait falling in LOOKUP or RESP aborts to IDLE with no state write; ccwait ignored in WB0/WB1/UPDATE (write-back always completes).
REQ-023 SHALL: cctrans, ccwrite, st_wen, snoop_dstore = 0 outside the states listed above; outputs decoded from registered state only.
REQ-024 SHALL: minimum latency request-to-IDLE: miss/Shared 4 cycles; Modified with dwait=0 5 cycles.
REQ-025 SHALL: ccwait held high through UPDATE starts no new snoop until one IDLE cycle has elapsed.

Reset
REQ-026 SHALL: RST=1 forces IDLE immediately, clears captured address, ccinv, hit and dirty registers; all outputs 0.
REQ-027 SHALL: RST mid write-back abandons the transfer; no st_wen issued.

Configuration
REQ-028 SHALL: macro SNOOP_STATS_EN defined -> add outputs snoop_hits 16 and snoop_wbs 16, saturating counters incremented on LOOKUP hit and on WB1 completion, cleared by RST; undefined -> ports and counters absent, behaviour otherwise identical.

Verification
REQ-029 SHALL: miss: frame 2 invalid, ccwait=1 addr 0x00000010 -> cctrans one cycle, ccwrite=0, st_wen never 1.
REQ-030 SHALL: M hit with ccinv=0: frame 1 tag match, dirty, data0=0xDEADBEEF data1=0xCAFEF00D, dwait=0 -> 0xDEADBEEF then 0xCAFEF00D with ccwrite=1, then st_wen=1 st_valid=1 st_dirty=0.
REQ-031 SHALL: M hit with ccinv=1, dwait high 3 cycles in WB0 -> snoop_dstore held 0xDEADBEEF 4 cycles, final st_valid=0 st_dirty=0.
REQ-032 SHALL: cache_busy=1 for 5 cycles with ccwait=1 -> FSM stays IDLE, LOOKUP begins cycle after cache_busy falls.
REQ-033 SHALL: RST pulse during WB1 -> next cycle all outputs 0, state IDLE, no st_wen.
REQ-034 SHALL: with SNOOP_STATS_EN, REQ-029 then REQ-030 -> snoop_hits=1, snoop_wbs=1.
